mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the cache-to-memory request interface (mem_req_*): accepts one single-word read or write request at a time and completes it after a programmable latency with a one-cycle ready pulse.
- Serves as the backing store behind the instruction cache in simulation and lab builds.
- Contains a word-addressed RAM, a request latch and a latency counter.

Parameters:
- ADDR_WIDTH, 10, word-index bits; RAM depth = 2**ADDR_WIDTH words of 32 bits.
- LATENCY, 4, cycles from request acceptance to the ready pulse; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- mem_req_addr  in  32  byte address; word index = mem_req_addr[ADDR_WIDTH+1:2].
- mem_req_valid  in  1  request valid.
- mem_req_wr  in  1  1 = write, 0 = read.
- mem_wr_data  in  32  write data.
- mem_req_data  out  32  read data; registered, valid during the ready cycle.
- mem_req_ready  out  1  one-cycle completion pulse.
- mem_busy  out  1  high while a request is latched and not yet completed.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE immediately.
  - mem_req_ready=0, mem_req_data=0, mem_busy=0, counter=0, latched request cleared.
  - RAM contents are not reset; they are zero-initialised at time 0 for simulation.
- States: IDLE, BUSY, RESP.
- IDLE:
  - On an edge with mem_req_valid=1, latch addr, wr and wdata, load counter with LATENCY-1, set mem_busy=1.
  - Next state is BUSY, or RESP directly if LATENCY=1.
- BUSY:
  - Decrement the counter each cycle; inputs are ignored (latched copy used).
  - When counter==1, next state is RESP.
- Entering RESP (same edge that asserts mem_req_ready):
  - Write: RAM[idx] <= latched wdata; mem_req_data holds its previous value.
  - Read: mem_req_data <= RAM[idx].
  - mem_req_ready=1 for exactly one cycle.
- RESP:
  - Next state is IDLE; mem_req_ready returns to 0 and mem_busy returns to 0.
  - mem_req_data holds its value until the next read completes.
- Timing: valid sampled at edge T0 means mem_req_ready is high in the cycle following edge T0+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Requester rule: after seeing ready, the requester either drops valid or presents the next request in the following cycle (IDLE then samples it). No request is accepted while in RESP; minimum spacing is LATENCY+1 cycles per request.
- Valid dropped during BUSY: the transaction still completes (write commits, ready pulses).
- Read-after-write to the same word: the following read returns the new data.
- Addresses: upper address bits above ADDR_WIDTH+1 and bits [1:0] are ignored, so accesses alias modulo the RAM size.
- Reset mid-operation: the transaction is aborted, no RAM write occurs, no ready pulse is issued, and the first post-reset valid starts a fresh request.

Optional Feature:
- Macro: MEM_RESPONDER_RAND_LAT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - At acceptance, effective latency = LATENCY + lfsr[1:0] (range LATENCY..LATENCY+3); the counter is sized for it.
  - Used to stress the cache's ready wait states.
- Undefined: no LFSR logic; latency is exactly LATENCY.

Test Plan:
- Write then read, LATENCY=4: write addr 0x0000_0010 data 0xDEADBEEF; ready 4 cycles after acceptance. Read 0x10 -> mem_req_data=0xDEADBEEF in the ready cycle.
- LATENCY=1: read accepted at edge T0 -> ready high in the very next cycle; back-to-back reads of 0x0 and 0x4 complete with ready pulses 2 cycles apart.
- Alias, ADDR_WIDTH=10: write 0x1234_5678 to 0x0000_1000; read 0x0000_0000 -> 0x1234_5678. Read 0x0000_0003 -> the word at index 0.
- Reset mid-op: write 0xCAFEF00D to 0x20, assert rst in the 2nd BUSY cycle -> no ready pulse, mem_busy=0 immediately. Subsequent read of 0x20 returns the prior value (0).
- Valid dropped in BUSY: write 0x0000_00AA to 0x40, deassert valid after 1 cycle -> ready still pulses at cycle 4; read 0x40 -> 0xAA.
- MEM_RESPONDER_RAND_LAT_EN defined, LATENCY=2: 100 random reads -> every ready-to-acceptance gap lies in 2..5, every read returns the correct data, and each gap value occurs at least once.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bundle between a cache-side requester and mem_responder.
//
// Handshake: the requester holds mem_req_valid with a stable address, write
// flag and write data until it is accepted in IDLE. The responder then signals
// completion with a single-cycle mem_req_ready pulse, and read data is valid on
// mem_req_data in that cycle. There is no back-pressure on ready. After seeing
// ready, the requester drops valid or presents the next request.
interface mem_responder_if;
  logic [31:0] mem_req_addr;
  logic        mem_req_valid;
  logic        mem_req_wr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_req_data;
  logic        mem_req_ready;
  logic        mem_busy;

  // Requester side (the cache, or a testbench driver).
  modport master (
    output mem_req_addr,
    output mem_req_valid,
    output mem_req_wr,
    output mem_wr_data,
    input  mem_req_data,
    input  mem_req_ready,
    input  mem_busy
  );

  // Responder side (mem_responder).
  modport slave (
    input  mem_req_addr,
    input  mem_req_valid,
    input  mem_req_wr,
    input  mem_wr_data,
    output mem_req_data,
    output mem_req_ready,
    output mem_busy
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with programmable latency.
//
// This block accepts one word read or write in IDLE and latches it. After
// LATENCY cycles it completes the request in the cycle that enters RESP. In
// that cycle the RAM is written, or the read data register is loaded. RESP
// lasts exactly one cycle and drives the mem_req_ready pulse.
//
// Optional build macro MEM_RESPONDER_RAND_LAT_EN: a 16-bit LFSR adds 0..3
// extra cycles to each request's latency to stress requester wait states.
//
// The RAM has no reset. Simulation relies on the simulator's zero
// initialisation of the array at time 0.
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_responder_if.slave    bus,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef MEM_RESPONDER_RAND_LAT_EN
  // Holds up to LATENCY+3 = 18.
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 4;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        eff_lat;
  logic                    accept;
  logic                    complete;

  logic [ADDR_WIDTH-1:0]   lat_idx_q;
  logic                    lat_wr_q;
  logic [31:0]             lat_wdata_q;

  // The completing access may come straight from the inputs (single-cycle
  // latency, completing on the accept edge) or from the latched copy.
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic                    acc_wr;
  logic [31:0]             acc_wdata;

  logic [31:0]             data_q;
  logic [31:0]             mem [DEPTH];

  // Address bits outside the word index are ignored, so accesses alias.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_req_addr[31:ADDR_WIDTH+2],
                              bus.mem_req_addr[1:0]};

`ifdef MEM_RESPONDER_RAND_LAT_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // The LFSR free-runs every cycle, independent of traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  assign eff_lat = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
  assign eff_lat = CNT_W'(LATENCY);
`endif

  // Next-state logic: accept in IDLE, count down in BUSY, complete on
  // entering RESP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_req_valid) begin
          accept = 1'b1;
          if (eff_lat == CNT_W'(1)) begin
            state_d  = RESP;
            complete = 1'b1;
            cnt_d    = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = eff_lat - CNT_W'(1);
          end
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d  = RESP;
          complete = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Select the source for the access that completes this cycle.
  always_comb begin
    acc_idx   = lat_idx_q;
    acc_wr    = lat_wr_q;
    acc_wdata = lat_wdata_q;
    if (state_q == IDLE) begin
      acc_idx   = bus.mem_req_addr[ADDR_WIDTH+1:2];
      acc_wr    = bus.mem_req_wr;
      acc_wdata = bus.mem_wr_data;
    end
  end

  // State and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch the request on acceptance. Inputs are ignored until the next IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_idx_q   <= '0;
      lat_wr_q    <= 1'b0;
      lat_wdata_q <= '0;
    end else if (accept) begin
      lat_idx_q   <= bus.mem_req_addr[ADDR_WIDTH+1:2];
      lat_wr_q    <= bus.mem_req_wr;
      lat_wdata_q <= bus.mem_wr_data;
    end
  end

  // Read data register. It loads only when a read completes and holds
  // through writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (complete && !acc_wr) begin
      data_q <= mem[acc_idx];
    end
  end

  // RAM write on completion. It is gated by rst so an aborted request
  // never commits.
  always_ff @(posedge clk) begin
    if (!rst && complete && acc_wr) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign bus.mem_req_ready = (state_q == RESP);
  assign bus.mem_busy      = (state_q != IDLE);
  assign bus.mem_req_data  = data_q;
  assign dbg_state         = state_q;

endmodule
